// File: rtl/gray_bin_tracker_if.sv
// Bus bundle for gray_bin_tracker: Gray pointer and error-clear in, decoded
// binary value, step/delta and error status out.
interface gray_bin_tracker_if #(
  parameter int W = 4
);
  logic [W-1:0] gray_async;
  logic         err_clr;
  logic [W-1:0] bin;
  logic         bin_valid;
  logic [W-1:0] delta;
  logic         step;
  logic         err;
  logic [7:0]   err_cnt;

  modport master (
    output gray_async, err_clr,
    input  bin, bin_valid, delta, step, err, err_cnt
  );

  modport slave (
    input  gray_async, err_clr,
    output bin, bin_valid, delta, step, err, err_cnt
  );
endinterface

// File: rtl/gray_bin_tracker.sv
// Synchronises an asynchronous Gray pointer, decodes it to binary, reports the
// per-cycle delta and flags Gray transitions that change more than one bit.
module gray_bin_tracker #(
  parameter int W      = 4,
  parameter bit STRICT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_bin_tracker_if.slave   bus
);

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t       r_state;
  logic [1:0]   r_fill_cnt;
  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] r_sync2_prev;
  logic [W-1:0] r_bin;
  logic [W-1:0] r_delta;
  logic         r_step;
  logic         r_bin_valid;
  logic         r_err;
  logic [7:0]   r_err_cnt;

  logic [W-1:0] w_bin_next;
  logic [W-1:0] w_delta_next;
  logic         w_violation;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_bit(input logic [W-1:0] x);
    return (x & (x - {{(W-1){1'b0}}, 1'b1})) != {W{1'b0}};
  endfunction

  // Decode, delta and transition-legality check on the synchronised sample.
  always_comb begin
    w_bin_next   = gray2bin(r_sync2);
    w_delta_next = w_bin_next - r_bin;
    if ((STRICT == 1'b1) && (r_state == TRACK)) begin
      w_violation = multi_bit(r_sync2 ^ r_sync2_prev);
    end else begin
      w_violation = 1'b0;
    end
  end

  // Synchroniser, decode register, fill/track sequencing and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_fill_cnt   <= 2'd0;
      r_sync1      <= {W{1'b0}};
      r_sync2      <= {W{1'b0}};
      r_sync2_prev <= {W{1'b0}};
      r_bin        <= {W{1'b0}};
      r_delta      <= {W{1'b0}};
      r_step       <= 1'b0;
      r_bin_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_sync1      <= bus.gray_async;
      r_sync2      <= r_sync1;
      r_sync2_prev <= r_sync2;
      r_bin        <= w_bin_next;

      case (r_state)
        FILL: begin
          r_delta <= {W{1'b0}};
          r_step  <= 1'b0;
          // Third edge after release: bin now carries a genuine sample.
          if (r_fill_cnt == 2'd2) begin
            r_state     <= TRACK;
            r_bin_valid <= 1'b1;
          end else begin
            r_fill_cnt <= r_fill_cnt + 2'd1;
          end
        end
        TRACK: begin
          r_delta <= w_delta_next;
          r_step  <= (w_delta_next != {W{1'b0}});
        end
        default: begin
          r_state     <= FILL;
          r_fill_cnt  <= 2'd0;
          r_delta     <= {W{1'b0}};
          r_step      <= 1'b0;
          r_bin_valid <= 1'b0;
        end
      endcase

      // A violation outranks a simultaneous clear and restarts the count at one.
      if (w_violation) begin
        r_err <= 1'b1;
        if (bus.err_clr) begin
          r_err_cnt <= 8'd1;
        end else if (r_err_cnt != 8'd255) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          r_err_cnt <= r_err_cnt;
        end
      end else if (bus.err_clr) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else begin
        r_err     <= r_err;
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign bus.bin       = r_bin;
  assign bus.bin_valid = r_bin_valid;
  assign bus.delta     = r_delta;
  assign bus.step      = r_step;
  assign bus.err       = r_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_bin_tracker.sv
// Directed scoreboard bench: a STRICT=1 and a STRICT=0 tracker see the same
// Gray stream; expected outputs are queued at drive time and popped at sample.
module tb_gray_bin_tracker;

  typedef struct {
    string      tag;
    logic [3:0] bin;
    logic       valid;
    logic [3:0] delta;
    logic       step;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  gray_bin_tracker_if #(.W(4)) u_if_s ();
  gray_bin_tracker_if #(.W(4)) u_if_n ();

  gray_bin_tracker #(.W(4), .STRICT(1'b1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_s)
  );

  gray_bin_tracker #(.W(4), .STRICT(1'b0)) u_dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] g, input logic clr);
    u_if_s.gray_async = g;
    u_if_n.gray_async = g;
    u_if_s.err_clr    = clr;
    u_if_n.err_clr    = clr;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] b, input logic v,
                      input logic [3:0] d, input logic s, input logic e,
                      input logic [7:0] c);
    exp_t x;
    x.tag = tag; x.bin = b; x.valid = v; x.delta = d;
    x.step = s; x.err = e; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".bin"},   {4'd0, u_if_s.bin},       {4'd0, x.bin});
      chk({x.tag, ".valid"}, {7'd0, u_if_s.bin_valid}, {7'd0, x.valid});
      chk({x.tag, ".delta"}, {4'd0, u_if_s.delta},     {4'd0, x.delta});
      chk({x.tag, ".step"},  {7'd0, u_if_s.step},      {7'd0, x.step});
      chk({x.tag, ".err"},   {7'd0, u_if_s.err},       {7'd0, x.err});
      chk({x.tag, ".cnt"},   u_if_s.err_cnt,           x.cnt);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] prev;
    logic [3:0] cur;
    checks = 0;
    errors = 0;

    // Held Gray 0110 from reset release: bin 4 after the third edge.
    rst_n = 1'b0;
    drive(4'b0110, 1'b0);
    #1;
    push("reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    push("fill2", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    push("fill3", 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    push("hold",  4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    tick(2); pop_check();
    tick(1); pop_check();
    tick(3); pop_check();

    // Fresh start at Gray 0, then count 1..15 and wrap back to 0.
    rst_n = 1'b0;
    drive(4'b0000, 1'b0);
    tick(1);
    rst_n = 1'b1;
    push("start0", 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    tick(3); pop_check();
    prev = 4'd0;
    for (int b = 1; b <= 16; b++) begin
      cur = 4'(b);
      g   = cur ^ (cur >> 1);
      push($sformatf("cnt%0d.lag", b),  prev, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
      push($sformatf("cnt%0d.hit", b),  cur,  1'b1, 4'd1, 1'b1, 1'b0, 8'd0);
      push($sformatf("cnt%0d.post", b), cur,  1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
      drive(g, 1'b0);
      tick(2); pop_check();
      tick(1); pop_check();
      tick(1); pop_check();
      prev = cur;
    end

    // Two-bit jump 0000 -> 0011.
    push("jump", 4'd2, 1'b1, 4'd2, 1'b1, 1'b1, 8'd1);
    drive(4'b0011, 1'b0);
    tick(3); pop_check();
    chk("ns_jump.err",   {7'd0, u_if_n.err},   8'd0);
    chk("ns_jump.cnt",   u_if_n.err_cnt,       8'd0);
    chk("ns_jump.bin",   {4'd0, u_if_n.bin},   8'd2);
    chk("ns_jump.delta", {4'd0, u_if_n.delta}, 8'd2);

    // 300 forced two-bit changes, one per cycle, ending on 0011.
    for (int i = 0; i < 300; i++) begin
      drive(((i % 2) == 0) ? 4'b0000 : 4'b0011, 1'b0);
      tick(1);
    end
    push("sat", 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 8'd255);
    tick(4); pop_check();
    chk("ns_sat.cnt", u_if_n.err_cnt, 8'd0);

    push("clr", 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    drive(4'b0011, 1'b1);
    tick(1); pop_check();
    drive(4'b0011, 1'b0);
    tick(1);

    // Clear coinciding with a violation: 0011 -> 0000, bin 2 -> 0 (delta 14).
    push("clr_vs_viol", 4'd0, 1'b1, 4'd14, 1'b1, 1'b1, 8'd1);
    drive(4'b0000, 1'b0);
    tick(2);
    drive(4'b0000, 1'b1);
    tick(1); pop_check();
    drive(4'b0000, 1'b0);

    // Move to bin 9 (Gray 1101, a three-bit change), then reset mid-stream.
    push("bin9", 4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 8'd2);
    drive(4'b1101, 1'b0);
    tick(4); pop_check();
    rst_n = 1'b0;
    #1;
    push("async_rst", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    pop_check();
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    push("rel1", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    push("rel2", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    push("rel3", 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    push("rel4", 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);
    tick(1); pop_check();
    tick(1); pop_check();
    tick(1); pop_check();
    tick(1); pop_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_bin_tracker.md
GRAY_BIN_TRACKER -- requirements
Module: gray_bin_tracker

Interface
REQ-001 SHALL have parameter W, default 4: width of the Gray-coded pointer (legal 2..16).
REQ-002 SHALL have parameter STRICT, default 1: 1 enables the multi-bit-change error check, 0 disables it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port gray_async, input, W bits: Gray-coded pointer, asynchronous to clk.
REQ-006 SHALL have port err_clr, input, 1 bit: synchronous clear for err and err_cnt.
REQ-007 SHALL have port bin, output, W bits: registered binary value decoded from the synchronized Gray input.
REQ-008 SHALL have port bin_valid, output, 1 bit: bin holds a genuine decoded sample.
REQ-009 SHALL have port delta, output, W bits: (bin - previous bin) mod 2^W.
REQ-010 SHALL have port step, output, 1 bit: one-cycle pulse when delta is nonzero.
REQ-011 SHALL have port err, output, 1 bit: sticky flag for an illegal Gray transition.
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating count of illegal transitions.

Function
REQ-013 SHALL pass gray_async through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-014 SHALL decode sync2 to binary with bin[W-1] = g[W-1] and bin[i] = bin[i+1] XOR g[i], then register the result into bin.
REQ-015 SHALL have a latency of 3 rising edges from a stable gray_async value to the matching bin value.
REQ-016 SHALL hold sync2_prev, the sync2 value registered one cycle earlier, for the error check.
REQ-017 SHALL implement states FILL and TRACK; FILL counts 3 edges after reset release, then moves to TRACK on the 3rd edge.
REQ-018 SHALL assert bin_valid from the first TRACK cycle and hold it until reset.
REQ-019 SHALL, in FILL, hold delta=0, step=0 and perform no error check.
REQ-020 SHALL, in TRACK, register delta = (new bin - current bin) mod 2^W every cycle, including wrap-around (e.g. W=4: 15 to 1 gives delta=2).
REQ-021 SHALL, in TRACK, assert step for exactly the cycle in which the registered delta is nonzero.
REQ-022 SHALL, in TRACK with STRICT=1, flag a violation when popcount(sync2 XOR sync2_prev) > 1; a violation sets err=1 and increments err_cnt, saturating at 255.
REQ-023 SHALL NOT flag a violation for a change of 0 or 1 bit, and SHALL NOT flag any violation when STRICT=0.
REQ-024 SHALL, when err_clr=1 with no violation in the same cycle, clear err to 0 and err_cnt to 0 on the next edge.
REQ-025 SHALL, when err_clr and a violation coincide, let the violation win: err=1, err_cnt=1.
REQ-026 SHALL compute bin and delta even in a violation cycle, and SHALL treat the erroneous value as the new reference.

Reset
REQ-027 SHALL, while rst_n=0, immediately force sync1, sync2, sync2_prev, bin, delta, step, err, err_cnt and bin_valid to 0, and the state to FILL.
REQ-028 SHALL, when rst_n is asserted mid-operation, discard all history; after release, bin_valid SHALL stay 0 for 3 edges and no delta or error SHALL be derived from pre-reset samples.

Verification (W=4, STRICT=1 unless stated)
REQ-029 SHALL cover: gray_async=4'b0110 held from reset release -> bin_valid=1 and bin=4 after the 3rd edge; delta=0 and step=0 throughout.
REQ-030 SHALL cover: the Gray sequence for binary 0..15..0, one value per 4 cycles -> bin follows with 3-cycle lag; step pulses once per change with delta=1, including the 15 to 0 wrap.
REQ-031 SHALL cover: gray_async jumps 4'b0000 to 4'b0011 in TRACK -> err=1, err_cnt=1, bin=2, delta=2, step=1.
REQ-032 SHALL cover: 300 forced two-bit changes followed by err_clr -> err_cnt saturates at 255; after err_clr, err=0 and err_cnt=0; with err_clr coinciding with a violation -> err=1, err_cnt=1.
REQ-033 SHALL cover: STRICT=0 with the same jump as REQ-031 -> err=0 and err_cnt=0, while bin=2 and delta=2.
REQ-034 SHALL cover: rst_n pulsed low mid-stream with bin=9 -> all outputs read 0 asynchronously; bin_valid=0 for 3 edges after release; no step pulse from the pre-reset value.
